// File: rtl/sp_ram_arb_pkg.sv
// Shared types and helpers for the two-master single-port RAM arbiter.
package sp_ram_arb_pkg;

  typedef logic master_id_t;

  typedef struct packed {
    logic       valid;
    master_id_t id;
    logic       we;
    logic       err;
  } resp_tag_t;

  localparam string ARB_ROUND_ROBIN = "ROUND_ROBIN";
  localparam string ARB_FIXED       = "FIXED";

  function automatic int clogb2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/sp_ram_rr_arb.sv
// Two-way arbiter: round-robin or fixed (m0 first) priority, one-hot grant.
module sp_ram_rr_arb
  import sp_ram_arb_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  logic       r_last_m1;
  logic [1:0] w_gnt;

  always_comb begin
    w_gnt = 2'b00;
    if (!i_rst) begin
      case (i_req)
        2'b01:   w_gnt = 2'b01;
        2'b10:   w_gnt = 2'b10;
        2'b11:   w_gnt = (FIXED_PRIO || r_last_m1) ? 2'b01 : 2'b10;
        default: w_gnt = 2'b00;
      endcase
    end
  end

  assign o_gnt = w_gnt;

  // Pointer holds the last winner; it only moves on a real grant.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_m1 <= 1'b1;
    end else if (|w_gnt) begin
      r_last_m1 <= w_gnt[1];
    end
  end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Shares one single-port byte-write RAM between two req/gnt/rvalid masters,
// with range checking and a 1- or 2-stage response tag pipeline.
module sp_ram_arbiter
  import sp_ram_arb_pkg::*;
#(
  parameter int    NB_COL       = 4,
  parameter int    COL_WIDTH    = 8,
  parameter int    RAM_DEPTH    = 16384,
  parameter int    ADDR_WIDTH   = 32,
  parameter int    READ_LATENCY = 1,
  parameter string ARB_MODE     = "ROUND_ROBIN",
  localparam int   RAW          = clogb2(RAM_DEPTH),
  localparam int   DW           = NB_COL * COL_WIDTH
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic                  m0_req_i,
  output logic                  m0_gnt_o,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic                  m0_we_i,
  input  logic [NB_COL-1:0]     m0_be_i,
  input  logic [DW-1:0]         m0_wdata_i,
  output logic                  m0_rvalid_o,
  output logic [DW-1:0]         m0_rdata_o,
  output logic                  m0_err_o,
  input  logic                  m1_req_i,
  output logic                  m1_gnt_o,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic                  m1_we_i,
  input  logic [NB_COL-1:0]     m1_be_i,
  input  logic [DW-1:0]         m1_wdata_i,
  output logic                  m1_rvalid_o,
  output logic [DW-1:0]         m1_rdata_o,
  output logic                  m1_err_o,
  output logic [RAW-1:0]        ram_addra_o,
  output logic [DW-1:0]         ram_dina_o,
  output logic [NB_COL-1:0]     ram_wea_o,
  output logic                  ram_ena_o,
  output logic                  ram_rsta_o,
  output logic                  ram_regcea_o,
  input  logic [DW-1:0]         ram_douta_i
);

  localparam int LOG_COL    = clogb2(NB_COL);
  localparam int WIW        = ADDR_WIDTH - LOG_COL;
  localparam bit FIXED_PRIO = (ARB_MODE == ARB_FIXED);

  logic [1:0]            w_gnt;
  logic                  w_grant;
  master_id_t            w_sel;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_we;
  logic [NB_COL-1:0]     w_be;
  logic [DW-1:0]         w_wdata;
  logic [WIW-1:0]        w_word;
  logic                  w_in_range;
  resp_tag_t             w_tag_in;
  resp_tag_t             w_tag_out;
  resp_tag_t             r_s1;
  logic                  w_regce;
  logic                  w_rv;
  logic                  w_data_ok;

  sp_ram_rr_arb #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
    .i_clk (clka),
    .i_rst (rsta),
    .i_req ({m1_req_i, m0_req_i}),
    .o_gnt (w_gnt)
  );

  assign m0_gnt_o = w_gnt[0];
  assign m1_gnt_o = w_gnt[1];
  assign w_grant  = |w_gnt;
  assign w_sel    = w_gnt[1];

  assign w_addr  = w_sel ? m1_addr_i  : m0_addr_i;
  assign w_we    = w_sel ? m1_we_i    : m0_we_i;
  assign w_be    = w_sel ? m1_be_i    : m0_be_i;
  assign w_wdata = w_sel ? m1_wdata_i : m0_wdata_i;

  assign w_word     = w_addr[ADDR_WIDTH-1:LOG_COL];
  assign w_in_range = (w_word < WIW'(RAM_DEPTH));

  // Out-of-range requests are granted but never touch the RAM.
  assign ram_addra_o = w_word[RAW-1:0];
  assign ram_dina_o  = w_wdata;
  assign ram_ena_o   = w_grant & w_in_range;
  assign ram_wea_o   = (ram_ena_o && w_we) ? w_be : '0;
  assign ram_rsta_o  = rsta;

  always_comb begin
    w_tag_in       = '0;
    w_tag_in.valid = w_grant;
    w_tag_in.id    = w_sel;
    w_tag_in.we    = w_we;
    w_tag_in.err   = ~w_in_range;
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      r_s1 <= '0;
    end else begin
      r_s1 <= w_tag_in;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      resp_tag_t r_s2;
      always_ff @(posedge clka) begin
        if (rsta) begin
          r_s2 <= '0;
        end else begin
          r_s2 <= r_s1;
        end
      end
      assign w_tag_out = r_s2;
      assign w_regce   = r_s1.valid;
    end else begin : g_lat1
      assign w_tag_out = r_s1;
      assign w_regce   = 1'b0;
    end
  endgenerate

  assign ram_regcea_o = w_regce & ~rsta;

  assign w_rv      = w_tag_out.valid & ~rsta;
  assign w_data_ok = ~w_tag_out.we & ~w_tag_out.err;

  assign m0_rvalid_o = w_rv & (w_tag_out.id == 1'b0);
  assign m1_rvalid_o = w_rv & (w_tag_out.id == 1'b1);
  assign m0_err_o    = m0_rvalid_o & w_tag_out.err;
  assign m1_err_o    = m1_rvalid_o & w_tag_out.err;
  assign m0_rdata_o  = (m0_rvalid_o && w_data_ok) ? ram_douta_i : '0;
  assign m1_rdata_o  = (m1_rvalid_o && w_data_ok) ? ram_douta_i : '0;

endmodule
